problema1_pio_in_irq: RTL and testbench

//   Parametrised Avalon-MM input PIO: the next generation of the single-bit input port.

---
 rtl/problema1_pio_in_irq.sv | 94 +++++++++
 tb/tb_problema1_pio_in_irq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/problema1_pio_in_irq.sv
// rtl/problema1_pio_in_irq.sv - Avalon-MM input PIO with synchroniser, edge capture and masked level irq
module problema1_pio_in_irq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned EDGE_TYPE  = 0,
    parameter logic [31:0] RESET_MASK = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] sync1;
    logic [DATA_WIDTH-1:0] sync2;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] edgecapture;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] rise;
    logic [DATA_WIDTH-1:0] fall;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] w1c;
    logic [DATA_WIDTH-1:0] edgecapture_nxt;
    logic [DATA_WIDTH-1:0] irqmask_nxt;
    logic [31:0]           rd_mux;
    logic                  wr;
    logic                  unused_wdata;

    assign unused_wdata = ^writedata;

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_det = rise;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_det = fall;
        end else begin : g_any
            assign edge_det = rise | fall;
        end
    endgenerate

    assign wr = chipselect & ~write_n;

    // A new edge in the same cycle as a W1C of that bit must keep the bit set.
    always_comb begin
        w1c             = '0;
        irqmask_nxt     = irqmask;
        if (wr && (address == 2'd3)) begin
            w1c = writedata[DATA_WIDTH-1:0];
        end
        if (wr && (address == 2'd2)) begin
            irqmask_nxt = writedata[DATA_WIDTH-1:0];
        end
        edgecapture_nxt = (edgecapture & ~w1c) | edge_det;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[DATA_WIDTH-1:0] = sync2;
            2'd2:    rd_mux[DATA_WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[DATA_WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    // irq is registered from next-state values so it rises on the same edge as the capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            prev        <= '0;
            edgecapture <= '0;
            irqmask     <= RESET_MASK[DATA_WIDTH-1:0];
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            sync1       <= in_port;
            sync2       <= sync1;
            prev        <= sync2;
            edgecapture <= edgecapture_nxt;
            irqmask     <= irqmask_nxt;
            readdata    <= rd_mux;
            irq         <= |(edgecapture_nxt & irqmask_nxt);
        end
    end

endmodule

// File: tb/tb_problema1_pio_in_irq.sv
// tb/tb_problema1_pio_in_irq.sv - scoreboard bench for three edge-type variants of the input PIO
module tb_problema1_pio_in_irq;

    localparam int RD  = 0;
    localparam int IRQ = 1;

    typedef struct {
        int          dut;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    chk_t q[$];
    int   req_n  = 0;
    int   pend_n = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    always #5 clk = ~clk;

    problema1_pio_in_irq #(.DATA_WIDTH(8), .EDGE_TYPE(0), .RESET_MASK(32'h00)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
    problema1_pio_in_irq #(.DATA_WIDTH(8), .EDGE_TYPE(1), .RESET_MASK(32'h00)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));
    problema1_pio_in_irq #(.DATA_WIDTH(8), .EDGE_TYPE(2), .RESET_MASK(32'h5A)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

    function automatic logic [31:0] dut_out(int d, int k);
        logic [31:0] r;
        logic        i;
        case (d)
            0:       begin r = rd0; i = irq0; end
            1:       begin r = rd1; i = irq1; end
            default: begin r = rd2; i = irq2; end
        endcase
        return (k == RD) ? r : {31'b0, i};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(int d, int k, logic [31:0] e, string n);
        chk_t c;
        c.dut  = d;
        c.kind = k;
        c.exp  = e;
        c.name = n;
        q.push_back(c);
        req_n++;
    endtask

    // Checks pushed before an edge are compared on the falling edge after it.
    always @(posedge clk) pend_n <= req_n;

    always @(negedge clk) begin
        for (int i = 0; i < pend_n; i++) begin
            chk_t c;
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: got empty queue, expected %0d items", pend_n);
            end else begin
                c = q.pop_front();
                check(c.name, dut_out(c.dut, c.kind), c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        req_n      = 0;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd2;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'hFF;
        @(negedge clk);

        // reset state, then FF at release seen as rising edges
        push(0, RD, 32'h0, "rst_rdata");
        push(0, IRQ, 32'h0, "rst_irq0");
        push(2, IRQ, 32'h0, "rst_irq2");
        rd(2'd2);
        tick();
        reset_n = 1'b1;
        push(0, RD, 32'h00, "rst_mask0");
        push(2, RD, 32'h5A, "rst_mask2");
        rd(2'd2);
        ticks(4);
        push(0, RD, 32'hFF, "rel_edge0");
        push(1, RD, 32'h00, "rel_edge1");
        push(2, RD, 32'hFF, "rel_edge2");
        push(0, IRQ, 32'h0, "rel_irq0");
        push(2, IRQ, 32'h1, "rel_irq2");
        rd(2'd3);
        wr(2'd2, 32'h0);
        wr(2'd3, 32'hFF);

        // data path
        in_port = 8'hA5;
        ticks(3);
        push(0, RD, 32'h000000A5, "data_a5");
        rd(2'd0);
        push(0, RD, 32'h0, "reserved");
        rd(2'd1);
        wr(2'd3, 32'hFF);

        // rising capture and irq latency
        wr(2'd2, 32'h01);
        push(0, RD, 32'h01, "mask_rdback");
        rd(2'd2);
        in_port = 8'hA4;
        ticks(3);
        in_port = 8'hA5;
        tick();
        push(0, IRQ, 32'h0, "irq_early");
        tick();
        push(0, IRQ, 32'h1, "irq_k2");
        tick();
        push(0, RD, 32'h01, "cap_bit0");
        rd(2'd3);
        push(0, IRQ, 32'h0, "irq_w1c");
        wr(2'd3, 32'h01);

        // masking
        wr(2'd2, 32'h0);
        in_port = 8'hAD;
        ticks(4);
        push(0, IRQ, 32'h0, "irq_masked");
        push(0, RD, 32'h08, "cap_bit3");
        rd(2'd3);
        push(0, IRQ, 32'h1, "irq_unmask");
        wr(2'd2, 32'h08);
        push(0, IRQ, 32'h0, "irq_remask");
        wr(2'd2, 32'h0);
        wr(2'd3, 32'hFF);

        // set wins over simultaneous W1C; W1C of zero changes nothing
        in_port = 8'hA9;
        ticks(4);
        wr(2'd3, 32'hFF);
        in_port = 8'hAD;
        ticks(2);
        wr(2'd3, 32'h04);
        push(0, RD, 32'h04, "collide0");
        push(1, RD, 32'h00, "collide1");
        push(2, RD, 32'h04, "collide2");
        rd(2'd3);
        wr(2'd3, 32'h00);
        push(0, RD, 32'h04, "w1c_zero");
        rd(2'd3);
        wr(2'd3, 32'h04);
        push(0, RD, 32'h00, "w1c_bit2");
        rd(2'd3);

        // edge type variants on a 1->0->1 pulse of bit 7
        wr(2'd3, 32'hFF);
        in_port = 8'h2D;
        ticks(4);
        push(0, RD, 32'h00, "fall_rise_only");
        push(1, RD, 32'h80, "fall_fall_only");
        push(2, RD, 32'h80, "fall_any");
        rd(2'd3);
        wr(2'd3, 32'hFF);
        in_port = 8'hAD;
        ticks(4);
        push(0, RD, 32'h80, "rise_rise_only");
        push(1, RD, 32'h00, "rise_fall_only");
        push(2, RD, 32'h80, "rise_any");
        rd(2'd3);

        // reset during a pending irq
        push(0, IRQ, 32'h1, "pre_rst_irq");
        wr(2'd2, 32'h80);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_irq", {31'b0, irq0}, 32'h0);
        check("async_rst_rdata", rd0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        ticks(5);
        push(0, RD, 32'hAD, "post_rst_cap");
        push(0, IRQ, 32'h0, "post_rst_irq");
        rd(2'd3);
        push(0, RD, 32'h00, "post_rst_mask");
        rd(2'd2);
        ticks(2);
        check("sb_empty", q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
